// File: rtl/relm_i2c_target.sv
// I2C target serving a byte-wide register bank through a sub-address pointer.
// Define RELM_I2C_TARGET_IRQ_EN to add the wdone_out write-complete pulse.
module relm_i2c_target #(
    parameter logic [6:0] ADDR = 7'h39,
    parameter int         WAR  = 4
) (
    input  logic           clk,
    input  logic           rst_n_in,
    input  logic           scl_in,
    input  logic           sda_in,
    output logic           sda_out,
    input  logic           host_we_in,
    input  logic [WAR-1:0] host_a_in,
    input  logic [7:0]     host_d_in,
    output logic [7:0]     host_q_out,
    output logic           busy_out
`ifdef RELM_I2C_TARGET_IRQ_EN
    ,
    output logic           wdone_out
`endif
);

    localparam int             DEPTH   = 1 << WAR;
    localparam logic [WAR-1:0] PTR_ONE = 1;

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_AACK, S_PTR, S_PACK,
        S_WDAT, S_WACK, S_RDAT, S_RACK, S_WAIT
    } state_t;

    logic scl_s1_q, scl_s2_q, scl_h_q;
    logic sda_s1_q, sda_s2_q, sda_h_q;

    // Synchroniser chain runs through reset so edge history stays true
    always_ff @(posedge clk) begin
        scl_s1_q <= scl_in;
        scl_s2_q <= scl_s1_q;
        scl_h_q  <= scl_s2_q;
        sda_s1_q <= sda_in;
        sda_s2_q <= sda_s1_q;
        sda_h_q  <= sda_s2_q;
    end

    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  = scl_s2_q & ~scl_h_q;
    assign scl_fall  = ~scl_s2_q & scl_h_q;
    assign start_det = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
    assign stop_det  = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;

    state_t         state_q;
    logic [3:0]     bcnt_q;
    logic [6:0]     shr_q;
    logic [6:0]     tx_q;
    logic [WAR-1:0] ptr_q;
    logic           rw_q;
    logic           ackdrv_q;
    logic           sda_q;
    logic           busy_q;
    logic [7:0]     hq_q;
    logic [7:0]     host_q_d;

    logic [7:0] bank_q [DEPTH];
    logic [7:0] byte_w;
    logic [7:0] rd_byte;
    logic       i2c_we;

    assign byte_w  = {shr_q, sda_s2_q};
    assign rd_byte = bank_q[ptr_q];
    assign i2c_we  = rst_n_in & ~start_det & ~stop_det & scl_rise
                   & (state_q == S_WDAT) & (bcnt_q == 4'd7);

    always_ff @(posedge clk) begin
        if (!rst_n_in) begin
            state_q  <= S_IDLE;
            bcnt_q   <= '0;
            shr_q    <= '0;
            tx_q     <= '0;
            ptr_q    <= '0;
            rw_q     <= 1'b0;
            ackdrv_q <= 1'b0;
            sda_q    <= 1'b1;
            busy_q   <= 1'b0;
        end else if (start_det) begin
            state_q  <= S_ADDR;
            bcnt_q   <= '0;
            ackdrv_q <= 1'b0;
            sda_q    <= 1'b1;
            busy_q   <= 1'b0;
        end else if (stop_det) begin
            state_q  <= S_IDLE;
            ackdrv_q <= 1'b0;
            sda_q    <= 1'b1;
            busy_q   <= 1'b0;
        end else if (scl_rise) begin
            unique case (state_q)
                S_ADDR, S_PTR, S_WDAT: begin
                    shr_q  <= byte_w[6:0];
                    bcnt_q <= bcnt_q + 4'd1;
                    if (bcnt_q == 4'd7) begin
                        bcnt_q <= '0;
                        if (state_q == S_ADDR) begin
                            if (byte_w[7:1] == ADDR) begin
                                state_q <= S_AACK;
                                busy_q  <= 1'b1;
                                rw_q    <= byte_w[0];
                            end else begin
                                state_q <= S_WAIT;
                            end
                        end else if (state_q == S_PTR) begin
                            ptr_q   <= byte_w[WAR-1:0];
                            state_q <= S_PACK;
                        end else begin
                            state_q <= S_WACK;
                        end
                    end
                end
                S_RACK: begin
                    if (!sda_s2_q) begin
                        ptr_q   <= ptr_q + PTR_ONE;
                        state_q <= S_RDAT;
                        bcnt_q  <= '0;
                    end else begin
                        state_q <= S_WAIT;
                        busy_q  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end else if (scl_fall) begin
            unique case (state_q)
                S_AACK, S_PACK, S_WACK: begin
                    if (!ackdrv_q) begin
                        ackdrv_q <= 1'b1;
                        sda_q    <= 1'b0;
                        if (state_q == S_WACK) ptr_q <= ptr_q + PTR_ONE;
                    end else begin
                        ackdrv_q <= 1'b0;
                        if (state_q == S_AACK && rw_q) begin
                            state_q <= S_RDAT;
                            tx_q    <= rd_byte[6:0];
                            sda_q   <= rd_byte[7];
                            bcnt_q  <= 4'd1;
                        end else begin
                            sda_q   <= 1'b1;
                            bcnt_q  <= '0;
                            state_q <= (state_q == S_AACK) ? S_PTR : S_WDAT;
                        end
                    end
                end
                S_RDAT: begin
                    // bcnt_q counts bits already put on the wire
                    if (bcnt_q == 4'd0) begin
                        tx_q   <= rd_byte[6:0];
                        sda_q  <= rd_byte[7];
                        bcnt_q <= 4'd1;
                    end else if (bcnt_q == 4'd8) begin
                        sda_q   <= 1'b1;
                        state_q <= S_RACK;
                        bcnt_q  <= '0;
                    end else begin
                        sda_q  <= tx_q[6];
                        tx_q   <= {tx_q[5:0], 1'b0};
                        bcnt_q <= bcnt_q + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // On a same-address collision the bus write wins
    always_ff @(posedge clk) begin
        if (i2c_we) bank_q[ptr_q] <= byte_w;
        if (host_we_in && !(i2c_we && host_a_in == ptr_q))
            bank_q[host_a_in] <= host_d_in;
    end

    always_comb begin
        host_q_d = bank_q[host_a_in];
        if (host_we_in) host_q_d = host_d_in;
        if (i2c_we && ptr_q == host_a_in) host_q_d = byte_w;
    end

    always_ff @(posedge clk) begin
        if (!rst_n_in) hq_q <= '0;
        else           hq_q <= host_q_d;
    end

    assign sda_out    = sda_q;
    assign busy_out   = busy_q;
    assign host_q_out = hq_q;

`ifdef RELM_I2C_TARGET_IRQ_EN
    logic wrote_q, wdone_q;

    always_ff @(posedge clk) begin
        if (!rst_n_in) begin
            wrote_q <= 1'b0;
            wdone_q <= 1'b0;
        end else begin
            wdone_q <= (start_det | stop_det) & wrote_q;
            if (start_det || stop_det) wrote_q <= 1'b0;
            else if (i2c_we)           wrote_q <= 1'b1;
        end
    end

    assign wdone_out = wdone_q;
`endif

endmodule
